sd_block_reader: RTL and testbench

SD_BLOCK_READER -- requirements
Module: sd_block_reader

---
 rtl/sd_block_reader.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// sd_block_reader
//   Reads one 512-byte block from an SD card in SPI mode (CMD17) through an
//   external byte-wide SPI engine. Issues the command with its CRC7, polls
//   for R1 and the 0xFE start token, streams the data bytes out with their
//   index, checks the CRC16 trailer and releases chip select with one
//   trailing 0xFF byte.
//
// Ports
//   control_clk_i   : clock
//   control_rst_i   : asynchronous reset, active high
//   rd_req_i        : one-cycle read request (accepted only when idle)
//   rd_addr_i       : CMD17 argument (block address)
//   busy_o          : transaction in progress
//   done_o          : one-cycle completion pulse
//   err_o           : qualifies done_o; 1 = transaction failed
//   err_code_o      : failure cause, held until the next accepted request
//                     (1 R1 error, 2 R1 timeout, 3 token timeout,
//                      4 data error token, 5 CRC16 mismatch)
//   byte_o          : received data byte
//   byte_valid_o    : one-cycle strobe per data byte
//   byte_index_o    : 0..511 position of byte_o in the block
//   spi_cs_n_o      : card chip select, active low
//   spi_tx_byte_o   : byte for the SPI engine to shift out
//   spi_start_o     : one-cycle start pulse to the SPI engine
//   spi_done_i      : one-cycle exchange-complete pulse from the engine
//   spi_rx_byte_i   : received byte, valid with spi_done_i
module sd_block_reader #(
    parameter int unsigned R1_TIMEOUT    = 8,
    parameter int unsigned TOKEN_TIMEOUT = 1024
) (
    input  logic        control_clk_i,
    input  logic        control_rst_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic [8:0]  byte_index_o,
    output logic        spi_cs_n_o,
    output logic [7:0]  spi_tx_byte_o,
    output logic        spi_start_o,
    input  logic        spi_done_i,
    input  logic [7:0]  spi_rx_byte_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_R1WAIT  = 3'd2;
    localparam logic [2:0] S_TOKWAIT = 3'd3;
    localparam logic [2:0] S_DATA    = 3'd4;
    localparam logic [2:0] S_CRC16   = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    localparam logic [2:0] E_R1      = 3'd1;
    localparam logic [2:0] E_R1_TO   = 3'd2;
    localparam logic [2:0] E_TOK_TO  = 3'd3;
    localparam logic [2:0] E_TOK_ERR = 3'd4;
    localparam logic [2:0] E_CRC     = 3'd5;

    localparam logic [7:0]  R1_LAST  = 8'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOKEN_TIMEOUT - 1);

    // CRC7 (x^7 + x^3 + 1), MSB first, one byte per call
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic [7:0] d;
        logic       fb;
        c = crc_in;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[6] ^ d[7];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
            d  = {d[6:0], 1'b0};
        end
        return c;
    endfunction

    // CRC16-CCITT (0x1021), MSB first, one byte per call
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = crc_in;
        d = data;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ d[7];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            d  = {d[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [2:0]  state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [7:0]  byte_q,     byte_d;
    logic        bvalid_q,   bvalid_d;
    logic [8:0]  idx_q,      idx_d;
    logic        cs_n_q,     cs_n_d;
    logic [7:0]  tx_q,       tx_d;
    logic        start_q,    start_d;
    logic        pend_q,     pend_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [7:0]  r1_cnt_q,   r1_cnt_d;
    logic [15:0] tok_cnt_q,  tok_cnt_d;
    logic [8:0]  dcnt_q,     dcnt_d;
    logic [6:0]  crc7_q,     crc7_d;
    logic [15:0] crc16_q,    crc16_d;
    logic [7:0]  crc_hi_q,   crc_hi_d;

    logic        xfer_done;
    logic        issue;
    logic [7:0]  issue_byte;
    logic        fail;
    logic [2:0]  fail_code;

    // A done pulse only counts while an exchange is outstanding; a pulse that
    // coincides with our own start pulse cannot belong to that exchange.
    assign xfer_done = pend_q && !start_q && spi_done_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        byte_d     = byte_q;
        bvalid_d   = 1'b0;
        idx_d      = idx_q;
        cs_n_d     = cs_n_q;
        tx_d       = tx_q;
        start_d    = 1'b0;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        r1_cnt_d   = r1_cnt_q;
        tok_cnt_d  = tok_cnt_q;
        dcnt_d     = dcnt_q;
        crc7_d     = crc7_q;
        crc16_d    = crc16_q;
        crc_hi_d   = crc_hi_q;
        issue      = 1'b0;
        issue_byte = 8'hFF;
        fail       = 1'b0;
        fail_code  = '0;

        case (state_q)
            S_IDLE: begin
                if (rd_req_i) begin
                    state_d    = S_CMD;
                    addr_d     = rd_addr_i;
                    busy_d     = 1'b1;
                    err_code_d = '0;
                    cs_n_d     = 1'b0;
                    cnt_d      = '0;
                    crc7_d     = '0;
                end
            end
            S_CMD: begin
                // cnt_q counts command bytes already issued; the CRC7 is
                // folded in as each of the first five bytes goes out.
                if (!pend_q && cnt_q < 3'd6) begin
                    issue = 1'b1;
                    case (cnt_q)
                        3'd0:    issue_byte = 8'h51;
                        3'd1:    issue_byte = addr_q[31:24];
                        3'd2:    issue_byte = addr_q[23:16];
                        3'd3:    issue_byte = addr_q[15:8];
                        3'd4:    issue_byte = addr_q[7:0];
                        default: issue_byte = {crc7_q, 1'b1};
                    endcase
                    if (cnt_q != 3'd5) crc7_d = crc7_byte(crc7_q, issue_byte);
                    cnt_d = cnt_q + 3'd1;
                end
                if (xfer_done && cnt_q == 3'd6) begin
                    state_d  = S_R1WAIT;
                    r1_cnt_d = '0;
                end
            end
            S_R1WAIT: begin
                if (xfer_done) begin
                    if (!spi_rx_byte_i[7]) begin
                        if (spi_rx_byte_i == 8'h00) begin
                            state_d   = S_TOKWAIT;
                            tok_cnt_d = '0;
                        end else begin
                            fail      = 1'b1;
                            fail_code = E_R1;
                        end
                    end else if (r1_cnt_q == R1_LAST) begin
                        fail      = 1'b1;
                        fail_code = E_R1_TO;
                    end else begin
                        r1_cnt_d = r1_cnt_q + 8'd1;
                    end
                end
            end
            S_TOKWAIT: begin
                if (xfer_done) begin
                    if (spi_rx_byte_i == 8'hFE) begin
                        state_d = S_DATA;
                        dcnt_d  = '0;
                        crc16_d = '0;
                    end else if (spi_rx_byte_i[7:4] == 4'h0) begin
                        fail      = 1'b1;
                        fail_code = E_TOK_ERR;
                    end else if (tok_cnt_q == TOK_LAST) begin
                        fail      = 1'b1;
                        fail_code = E_TOK_TO;
                    end else begin
                        tok_cnt_d = tok_cnt_q + 16'd1;
                    end
                end
            end
            S_DATA: begin
                if (xfer_done) begin
                    byte_d   = spi_rx_byte_i;
                    idx_d    = dcnt_q;
                    bvalid_d = 1'b1;
                    crc16_d  = crc16_byte(crc16_q, spi_rx_byte_i);
                    if (dcnt_q == 9'd511) begin
                        state_d = S_CRC16;
                        cnt_d   = '0;
                    end else begin
                        dcnt_d = dcnt_q + 9'd1;
                    end
                end
            end
            S_CRC16: begin
                if (xfer_done) begin
                    if (cnt_q == 3'd0) begin
                        crc_hi_d = spi_rx_byte_i;
                        cnt_d    = 3'd1;
                    end else if ({crc_hi_q, spi_rx_byte_i} == crc16_q) begin
                        state_d = S_FINISH;
                        cs_n_d  = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_CRC;
                    end
                end
            end
            default: begin
                // FINISH / ERROR: chip select is already high; the trailer
                // byte is issued below, its completion ends the transaction.
                if (xfer_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = (state_q == S_ERROR);
                end
            end
        endcase

        if (fail) begin
            state_d    = S_ERROR;
            err_code_d = fail_code;
            cs_n_d     = 1'b1;
        end

        // Every non-command, non-idle state keeps one 0xFF exchange in flight.
        if (state_q != S_IDLE && state_q != S_CMD && !pend_q) begin
            issue      = 1'b1;
            issue_byte = 8'hFF;
        end

        if (issue) begin
            start_d = 1'b1;
            pend_d  = 1'b1;
            tx_d    = issue_byte;
        end
        if (xfer_done) pend_d = 1'b0;
    end

    always_ff @(posedge control_clk_i or posedge control_rst_i) begin
        if (control_rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            byte_q     <= '0;
            bvalid_q   <= 1'b0;
            idx_q      <= '0;
            cs_n_q     <= 1'b1;
            tx_q       <= 8'hFF;
            start_q    <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            r1_cnt_q   <= '0;
            tok_cnt_q  <= '0;
            dcnt_q     <= '0;
            crc7_q     <= '0;
            crc16_q    <= '0;
            crc_hi_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            byte_q     <= byte_d;
            bvalid_q   <= bvalid_d;
            idx_q      <= idx_d;
            cs_n_q     <= cs_n_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            r1_cnt_q   <= r1_cnt_d;
            tok_cnt_q  <= tok_cnt_d;
            dcnt_q     <= dcnt_d;
            crc7_q     <= crc7_d;
            crc16_q    <= crc16_d;
            crc_hi_q   <= crc_hi_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_code_o    = err_code_q;
    assign byte_o        = byte_q;
    assign byte_valid_o  = bvalid_q;
    assign byte_index_o  = idx_q;
    assign spi_cs_n_o    = cs_n_q;
    assign spi_tx_byte_o = tx_q;
    assign spi_start_o   = start_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// tb_sd_block_reader
//   Table of read scenarios applied to sd_block_reader through a small SPI
//   engine + SD card model, plus hand-written sequences for back-to-back
//   requests, stray spi_done_i pulses and reset in the middle of a block.
module tb_sd_block_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_code_o;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic [8:0]  byte_index_o;
    logic        spi_cs_n_o;
    logic [7:0]  spi_tx_byte_o;
    logic        spi_start_o;
    logic        spi_done_i;
    logic [7:0]  spi_rx_byte_i;

    always #5 clk = ~clk;

    sd_block_reader #(.R1_TIMEOUT(8), .TOKEN_TIMEOUT(1024)) dut (
        .control_clk_i (clk),
        .control_rst_i (rst),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .byte_index_o  (byte_index_o),
        .spi_cs_n_o    (spi_cs_n_o),
        .spi_tx_byte_o (spi_tx_byte_o),
        .spi_start_o   (spi_start_o),
        .spi_done_i    (spi_done_i),
        .spi_rx_byte_i (spi_rx_byte_i)
    );

    int total = 0;
    int bad   = 0;

    // written by the main sequence only
    logic [7:0] card_mem [0:2047];
    logic [7:0] data_mem [0:511];
    int         card_base   = 0;
    int         strobe_base = 0;
    int         inject_req  = 0;

    // written by the engine/monitor only
    logic [7:0] tx_log [0:2047];
    int         xchg_total = 0, vstrobe_total = 0, done_total = 0;
    int         viol_total = 0, idx_bad_total = 0, inject_ack = 0;
    int         busy_cnt = 0, neg_cnt = 0, last_done_neg = -10, pos;
    logic [7:0] cur_tx = 8'hFF, cur_rx = 8'hFF;

    // SPI engine + card: each start completes two negedges later with the
    // next card byte; also watches the strobe stream and the one-outstanding
    // exchange rule.
    initial begin
        spi_done_i    = 1'b0;
        spi_rx_byte_i = 8'h00;
        forever begin
            @(negedge clk);
            neg_cnt++;
            spi_done_i = 1'b0;
            if (byte_valid_o) begin
                if (byte_index_o !== 9'(vstrobe_total - strobe_base) || byte_o !== data_mem[byte_index_o])
                    idx_bad_total++;
                vstrobe_total++;
            end
            if (done_o) done_total++;
            if (busy_cnt > 0) begin
                if (spi_tx_byte_o !== cur_tx) viol_total++;
                busy_cnt--;
                if (busy_cnt == 0) begin
                    spi_done_i    = 1'b1;
                    spi_rx_byte_i = cur_rx;
                    last_done_neg = neg_cnt;
                end
            end else if (inject_req != inject_ack && !spi_start_o) begin
                inject_ack    = inject_req;
                spi_done_i    = 1'b1;
                spi_rx_byte_i = 8'h00;
            end
            if (spi_start_o) begin
                if (busy_cnt != 0 || neg_cnt < last_done_neg + 2) viol_total++;
                cur_tx = spi_tx_byte_o;
                pos    = xchg_total - card_base;
                if (pos >= 0 && pos < 2048) begin
                    tx_log[pos] = cur_tx;
                    cur_rx      = card_mem[pos];
                end else begin
                    cur_rx = 8'hFF;
                end
                xchg_total++;
                busy_cnt = 2;
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        int          r1_delay;
        logic [7:0]  r1_val;
        int          tok_delay;
        logic [7:0]  tok_val;
        bit          tok_none;
        bit          data_idx;
        bit          crc_bad;
        int          inject_at;
        bit          exp_err;
        logic [2:0]  exp_code;
        int          exp_strobes;
        int          exp_xchg;
    } scn_t;

    scn_t       scn [7];
    logic [7:0] exp_cmd [6];
    int         viol0, idxbad0;
    logic [2:0] prev_code = 3'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ msg[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_ref();
        logic [15:0] c;
        logic        fb;
        c = '0;
        for (int n = 0; n < 512; n++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ data_mem[n][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic setup(input int k);
        int          p;
        logic [15:0] crc;
        logic [39:0] msg;
        for (int i = 0; i < 2048; i++) card_mem[i] = 8'hFF;
        for (int i = 0; i < 512; i++) data_mem[i] = scn[k].data_idx ? 8'(i) : 8'h00;
        crc = crc16_ref();
        if (scn[k].crc_bad) crc = crc ^ 16'h8001;
        card_mem[6 + scn[k].r1_delay] = scn[k].r1_val;
        p = 6 + scn[k].r1_delay + 1;
        if (!scn[k].tok_none) begin
            card_mem[p + scn[k].tok_delay] = scn[k].tok_val;
            p = p + scn[k].tok_delay + 1;
            for (int i = 0; i < 512; i++) card_mem[p + i] = data_mem[i];
            card_mem[p + 512] = crc[15:8];
            card_mem[p + 513] = crc[7:0];
        end
        msg = {8'h51, scn[k].addr};
        exp_cmd[0] = 8'h51;
        exp_cmd[1] = scn[k].addr[31:24];
        exp_cmd[2] = scn[k].addr[23:16];
        exp_cmd[3] = scn[k].addr[15:8];
        exp_cmd[4] = scn[k].addr[7:0];
        exp_cmd[5] = {crc7_ref(msg), 1'b1};
        for (int i = 0; i < 2048; i++) tx_log[i] = 8'h00;
        card_base   = xchg_total;
        strobe_base = vstrobe_total;
        viol0       = viol_total;
        idxbad0     = idx_bad_total;
    endtask

    task automatic request(input logic [31:0] a);
        rd_req_i  = 1'b1;
        rd_addr_i = a;
        @(negedge clk);
        rd_req_i  = 1'b0;
        chk("busy_after_req", busy_o, 1'b1);
        chk("cs_low_after_req", spi_cs_n_o, 1'b0);
        chk("code_cleared", err_code_o, 3'd0);
    endtask

    task automatic run(input int k, input bit chain);
        bit ok;
        int nonff;
        if (!chain) begin
            repeat (2) @(negedge clk);
            chk("code_held", err_code_o, prev_code);
        end else begin
            chk("done_at_chain_req", done_o, 1'b1);
        end
        setup(k);
        request(scn[k].addr);
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (c == scn[k].inject_at && scn[k].inject_at != 0) inject_req++;
            @(negedge clk);
            if (done_o) begin ok = 1'b1; break; end
        end
        chk("done_seen", ok, 1'b1);
        chk("err", err_o, scn[k].exp_err);
        chk("err_code", err_code_o, scn[k].exp_code);
        chk("busy_at_done", busy_o, 1'b0);
        chk("cs_at_done", spi_cs_n_o, 1'b1);
        chk("strobes", vstrobe_total - strobe_base, scn[k].exp_strobes);
        chk("idx_data", idx_bad_total - idxbad0, 0);
        chk("exchanges", xchg_total - card_base, scn[k].exp_xchg);
        for (int j = 0; j < 6; j++) chk("cmd_byte", tx_log[j], exp_cmd[j]);
        if (scn[k].addr == 32'h0) chk("cmd_crc_addr0", tx_log[5], 8'h55);
        nonff = 0;
        for (int j = 6; j < scn[k].exp_xchg && j < 2048; j++) if (tx_log[j] !== 8'hFF) nonff++;
        chk("poll_bytes_ff", nonff, 0);
        chk("spi_protocol", viol_total - viol0, 0);
        prev_code = scn[k].exp_code;
    endtask

    initial begin
        bit found;
        int d0, s0, x0;

        //            addr          r1d r1v   tkd tkv    none idx bad inj err code strb xchg
        scn[0] = '{32'h0000_0000, 0, 8'h00, 3, 8'hFE, 1'b0, 1'b0, 1'b0, 0,  1'b0, 3'd0, 512, 526};
        scn[1] = '{32'h1234_5678, 2, 8'h04, 0, 8'hFE, 1'b0, 1'b0, 1'b0, 0,  1'b1, 3'd1, 0,   10};
        scn[2] = '{32'hA5A5_0F0F, 8, 8'hFF, 0, 8'hFE, 1'b0, 1'b0, 1'b0, 0,  1'b1, 3'd2, 0,   15};
        scn[3] = '{32'h0000_0200, 0, 8'h00, 0, 8'h0B, 1'b0, 1'b0, 1'b0, 0,  1'b1, 3'd4, 0,   9};
        scn[4] = '{32'h0000_0400, 0, 8'h00, 0, 8'hFE, 1'b1, 1'b0, 1'b0, 0,  1'b1, 3'd3, 0,   1032};
        scn[5] = '{32'h0000_0001, 0, 8'h00, 3, 8'hFE, 1'b0, 1'b1, 1'b1, 0,  1'b1, 3'd5, 512, 526};
        scn[6] = '{32'hDEAD_BEEF, 1, 8'h00, 0, 8'hFE, 1'b0, 1'b1, 1'b0, 30, 1'b0, 3'd0, 512, 524};

        for (int i = 0; i < 512; i++) data_mem[i] = 8'h00;
        for (int i = 0; i < 2048; i++) card_mem[i] = 8'hFF;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cs", spi_cs_n_o, 1'b1);
        chk("rst_tx", spi_tx_byte_o, 8'hFF);
        chk("rst_start", spi_start_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_bvalid", byte_valid_o, 1'b0);
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_idx", byte_index_o, 9'd0);
        chk("rst_code", err_code_o, 3'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run(k, 1'b0);

        // request in the same cycle as done_o
        run(3, 1'b0);
        run(1, 1'b1);

        // stray spi_done_i while idle
        x0 = xchg_total;
        d0 = done_total;
        inject_req++;
        repeat (6) @(negedge clk);
        chk("stray_busy", busy_o, 1'b0);
        chk("stray_start", xchg_total - x0, 0);
        chk("stray_done", done_total - d0, 0);

        // reset in the middle of the data phase
        setup(6);
        request(scn[6].addr);
        found = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (byte_valid_o && byte_index_o == 9'd100) begin found = 1'b1; break; end
        end
        chk("reached_idx100", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", spi_cs_n_o, 1'b1);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_bvalid", byte_valid_o, 1'b0);
        chk("mid_rst_idx", byte_index_o, 9'd0);
        chk("mid_rst_start", spi_start_o, 1'b0);
        chk("mid_rst_tx", spi_tx_byte_o, 8'hFF);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        d0 = done_total;
        s0 = vstrobe_total;
        repeat (30) @(negedge clk);
        chk("post_rst_no_done", done_total - d0, 0);
        chk("post_rst_no_strobe", vstrobe_total - s0, 0);
        chk("post_rst_idle", busy_o, 1'b0);
        prev_code = 3'd0;
        run(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
